dma_fifo: RTL

- Byte-granular FIFO that buffers data between the peripheral-side and memory-side AHB masters when the DMA stream runs with direct mode disabled.
- Sits on the FIFO interface of the stream controller:
  - The controller drives the put/pull strobes, transfer sizes and write data.
  - This block returns read data and the free/stored byte counts that the masters use to size their bursts.
- Each access moves 1, 2 or 4 bytes, little-endian.

---
 rtl/dma_fifo.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/dma_fifo.sv
//------------------------------------------------------------------------------
// Module      : dma_fifo
// Description : Byte-granular little-endian FIFO between the peripheral-side
//               and memory-side masters of a DMA stream (1/2/4-byte accesses).
//               Optional threshold flag enabled by macro DMA_FIFO_THRESH_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dma_fifo #(
    parameter int FIFO_SIZE_EXP = 5
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_clear,
    input  logic [1:0]               i_numb_bytes_put,
    input  logic [1:0]               i_numb_bytes_pull,
    input  logic                     i_fifo_put,
    input  logic                     i_fifo_pull,
    input  logic [31:0]              i_fifo_wdata,
`ifdef DMA_FIFO_THRESH_EN
    input  logic [1:0]               i_fth,
    output logic                     o_thresh,
`endif
    output logic [31:0]              o_fifo_rdata,
    output logic [FIFO_SIZE_EXP:0]   o_fifo_left_put,
    output logic [FIFO_SIZE_EXP:0]   o_fifo_left_pull,
    output logic                     o_empty,
    output logic                     o_full,
    output logic                     o_overflow,
    output logic                     o_underflow
);

    localparam int              E       = FIFO_SIZE_EXP;
    localparam int              DEPTH   = 2 ** FIFO_SIZE_EXP;
    localparam logic [E:0]      C_DEPTH = (E+1)'(DEPTH);

    function automatic logic [2:0] size_dec(input logic [1:0] code);
        case (code)
            2'd0:    size_dec = 3'd1;
            2'd1:    size_dec = 3'd2;
            default: size_dec = 3'd4;
        endcase
    endfunction

    logic [7:0]   r_mem [DEPTH];
    logic [E-1:0] r_wptr;
    logic [E-1:0] r_rptr;
    logic [E:0]   r_level;
    logic         r_overflow;
    logic         r_underflow;

    logic [2:0]   w_np;
    logic [2:0]   w_nr;
    logic [E:0]   w_np_ext;
    logic [E:0]   w_nr_ext;
    logic [E:0]   w_free;
    logic         w_put_ok;
    logic         w_pull_ok;
    logic         w_flush;
    logic [E:0]   w_level_nxt;

    assign w_np      = size_dec(i_numb_bytes_put);
    assign w_nr      = size_dec(i_numb_bytes_pull);
    assign w_np_ext  = {{(E-2){1'b0}}, w_np};
    assign w_nr_ext  = {{(E-2){1'b0}}, w_nr};
    assign w_free    = C_DEPTH - r_level;
    assign w_flush   = i_reset | i_clear;

    // Both checks use pre-edge counts, so a same-cycle pull never frees room for the put.
    assign w_put_ok  = i_fifo_put  && (w_np_ext <= w_free);
    assign w_pull_ok = i_fifo_pull && (w_nr_ext <= r_level);

    assign w_level_nxt = r_level
                       + (w_put_ok  ? w_np_ext : '0)
                       - (w_pull_ok ? w_nr_ext : '0);

    // Storage is deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (w_put_ok && !w_flush) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < w_np)
                    r_mem[r_wptr + E'(k)] <= i_fifo_wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_flush) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_put_ok)
                r_wptr <= r_wptr + w_np_ext[E-1:0];
            if (w_pull_ok)
                r_rptr <= r_rptr + w_nr_ext[E-1:0];
            if (i_fifo_put && !w_put_ok)
                r_overflow <= 1'b1;
            if (i_fifo_pull && !w_pull_ok)
                r_underflow <= 1'b1;
            r_level <= w_level_nxt;
        end
    end

    // Bytes beyond the stored level read as zero, so short reads are well defined.
    always_comb begin
        o_fifo_rdata = '0;
        for (int k = 0; k < 4; k++) begin
            if ((3'(k) < w_nr) && ((E+1)'(k) < r_level))
                o_fifo_rdata[8*k +: 8] = r_mem[r_rptr + E'(k)];
        end
    end

    assign o_fifo_left_pull = r_level;
    assign o_fifo_left_put  = w_free;
    assign o_empty          = (r_level == '0);
    assign o_full           = (w_free == '0);
    assign o_overflow       = r_overflow;
    assign o_underflow      = r_underflow;

`ifdef DMA_FIFO_THRESH_EN
    logic [E:0] w_thr_level;
    logic       r_thresh;

    // (fth+1) quarters of the depth.
    assign w_thr_level = {{(E-2){1'b0}}, ({1'b0, i_fth} + 3'd1)} << (E-2);

    always_ff @(posedge i_clk) begin
        if (w_flush)
            r_thresh <= 1'b0;
        else
            r_thresh <= (w_level_nxt >= w_thr_level);
    end

    assign o_thresh = r_thresh;
`endif

endmodule

`default_nettype wire
